// File: rtl/dmem_pkg.sv
// Shared types and lane-mask helper for the byte-addressable data memory.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL} size_e;

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  function automatic logic [3:0] lane_mask(size_e size, logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_byte_bank.sv
// One 8-bit lane of the data memory: synchronous write, registered read.
module dmem_byte_bank #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [7:0]                     wdata_i,
  output logic [7:0]                     rdata_o
);

  logic [7:0] mem_q [DEPTH_WORDS];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_byte_ctrl.sv
// Byte/halfword/word data memory with fault checks, one-cycle registered
// response and a post-reset zeroing sweep.
module dmem_byte_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              init_done
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          rsp_valid_q;

  logic          accept;
  logic          clearing;
  size_e         size_w;
  logic          fault_w;
  logic [3:0]    mask_w;
  logic [31:0]   wdata_w;
  logic [AW-1:0] bank_addr;
  logic [3:0]    bank_we;
  logic [31:0]   bank_wdata;
  logic [31:0]   bank_rdata;

  size_e         size_q;
  logic          signed_q;
  logic [1:0]    off_q;
  logic          we_q;
  logic          fault_q;

  assign clearing  = (state_q == S_CLEAR);
  assign req_ready = (state_q == S_IDLE);
  assign init_done = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign size_w    = size_e'(req_size);
  assign mask_w    = lane_mask(size_w, req_addr[1:0]);

  always_comb begin
    fault_w = 1'b0;
    case (size_w)
      SZ_HALF:    fault_w = req_addr[0];
      SZ_WORD:    fault_w = |req_addr[1:0];
      SZ_ILLEGAL: fault_w = 1'b1;
      default:    fault_w = 1'b0;
    endcase
    if (|req_addr[ADDR_W-1:AW+2]) begin
      fault_w = 1'b1;
    end
  end

  // Narrow store data is replicated so every candidate lane sees it.
  always_comb begin
    case (size_w)
      SZ_BYTE: wdata_w = {4{req_wdata[7:0]}};
      SZ_HALF: wdata_w = {2{req_wdata[15:0]}};
      default: wdata_w = req_wdata;
    endcase
  end

  assign bank_addr  = clearing ? cnt_q : req_addr[AW+1:2];
  assign bank_we    = clearing ? 4'b1111
                    : ((accept && req_we && !fault_w) ? mask_w : 4'b0000);
  assign bank_wdata = clearing ? 32'd0 : wdata_w;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    dmem_byte_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
      .clk     (clk),
      .addr_i  (bank_addr),
      .we_i    (bank_we[l]),
      .re_i    (accept),
      .wdata_i (bank_wdata[8*l +: 8]),
      .rdata_o (bank_rdata[8*l +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Response attributes; gated by rsp_valid_q so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      size_q   <= size_w;
      signed_q <= req_signed;
      off_q    <= req_addr[1:0];
      we_q     <= req_we;
      fault_q  <= fault_w;
    end
  end

  function automatic logic [31:0] extend(logic [31:0] word, size_e size,
                                         logic [1:0] off, logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_valid_q && fault_q;
  assign rsp_rdata = (rsp_valid_q && !fault_q && !we_q)
                   ? extend(bank_rdata, size_q, off_q, signed_q) : 32'd0;

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Directed bench for dmem_byte_ctrl with hand-computed expectations.
module tb_dmem_byte_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        init_done;

  int checks = 0;
  int errors = 0;
  int cyc;

  dmem_byte_ctrl #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request for one edge, then check the response it produces.
  task automatic xact(input string tag, input logic we, input logic [1:0] sz,
                      input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_flt);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_rd"}, rsp_rdata, exp_rd);
    check({tag, "_flt"}, {31'd0, rsp_fault}, {31'd0, exp_flt});
  endtask

  task automatic wait_ready(input string tag);
    cyc = 0;
    while (!req_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_clear_cycles"}, cyc, 32'd64);
    check({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_init",  {31'd0, init_done}, 32'd0);
    check("rst_vld",   {31'd0, rsp_valid}, 32'd0);
    check("rst_rd",    rsp_rdata, 32'd0);
    check("rst_flt",   {31'd0, rsp_fault}, 32'd0);
    reset = 1'b0;
    wait_ready("boot");

    xact("ld0_init",   1'b0, 2'b10, 1'b0, 32'd0,   32'd0, 32'd0, 1'b0);
    xact("ld252_init", 1'b0, 2'b10, 1'b0, 32'd252, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check("vld_drop", {31'd0, rsp_valid}, 32'd0);

    xact("st0",   1'b1, 2'b10, 1'b0, 32'd0,   32'd1,  32'd0, 1'b0);
    xact("ld0",   1'b0, 2'b10, 1'b0, 32'd0,   32'd0,  32'd1, 1'b0);
    xact("st100", 1'b1, 2'b10, 1'b0, 32'd100, 32'd66, 32'd0, 1'b0);
    xact("ld100", 1'b0, 2'b10, 1'b0, 32'd100, 32'd0,  32'h42, 1'b0);

    xact("st_mis",  1'b1, 2'b10, 1'b0, 32'd1,   32'd77, 32'd0, 1'b1);
    xact("ld0_chk", 1'b0, 2'b10, 1'b0, 32'd0,   32'd0,  32'd1, 1'b0);
    xact("hw_mis",  1'b0, 2'b01, 1'b0, 32'd3,   32'd0,  32'd0, 1'b1);
    xact("sz_ill",  1'b0, 2'b11, 1'b0, 32'd0,   32'd0,  32'd0, 1'b1);
    xact("oor",     1'b0, 2'b10, 1'b0, 32'd256, 32'd0,  32'd0, 1'b1);

    xact("st8",    1'b1, 2'b10, 1'b0, 32'd8,  32'h11223344, 32'd0, 1'b0);
    xact("stb10",  1'b1, 2'b00, 1'b0, 32'd10, 32'h000000AA, 32'd0, 1'b0);
    xact("ld8",    1'b0, 2'b10, 1'b0, 32'd8,  32'd0, 32'h11AA3344, 1'b0);
    xact("lbs10",  1'b0, 2'b00, 1'b1, 32'd10, 32'd0, 32'hFFFFFFAA, 1'b0);
    xact("lbu10",  1'b0, 2'b00, 1'b0, 32'd10, 32'd0, 32'h000000AA, 1'b0);
    xact("lhs10",  1'b0, 2'b01, 1'b1, 32'd10, 32'd0, 32'h000011AA, 1'b0);
    xact("lhu8",   1'b0, 2'b01, 1'b0, 32'd8,  32'd0, 32'h00003344, 1'b0);
    xact("lbs11",  1'b0, 2'b00, 1'b1, 32'd11, 32'd0, 32'h00000011, 1'b0);
    xact("sth8",   1'b1, 2'b01, 1'b0, 32'd8,  32'h0000BEEF, 32'd0, 1'b0);
    xact("lhs8",   1'b0, 2'b01, 1'b1, 32'd8,  32'd0, 32'hFFFFBEEF, 1'b0);

    // Back-to-back store then load to the same word.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'd12; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = 32'd0;
    check("b2b_st_vld", {31'd0, rsp_valid}, 32'd1);
    check("b2b_st_rd",  rsp_rdata, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_ld_vld", {31'd0, rsp_valid}, 32'd1);
    check("b2b_ld_rd",  rsp_rdata, 32'hDEADBEEF);

    // Reset arriving together with a request drops its response.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd12; reset = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b0;
    check("mid_rst_vld",   {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    wait_ready("reclear");
    xact("ld12_cleared", 1'b0, 2'b10, 1'b0, 32'd12, 32'd0, 32'd0, 1'b0);
    xact("ld0_cleared",  1'b0, 2'b10, 1'b0, 32'd0,  32'd0, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
